// File: rtl/phys_tag_alloc_ctrl.sv
// Rename-stage controller that sits in front of the physical-tag free-list FIFO.
// Optional stall counter: define ALLOC_STALL_STATS_EN to add the stall_cycles output.
module phys_tag_alloc_ctrl #(
   parameter int NUM_PREGS = 64,
   parameter int TAG_W     = 6,
   parameter int WIDTH     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_valid,
   input  logic [WIDTH-1:0]             alloc_en,
   output logic                         alloc_ready,
   output logic [WIDTH-1:0][TAG_W-1:0]  alloc_tag,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             free_en,
   input  logic [WIDTH-1:0][TAG_W-1:0]  free_tag,
   output logic                         fl_rst,
   output logic [WIDTH-1:0]             fl_get_en,
   output logic [WIDTH-1:0]             fl_put_en,
   output logic [WIDTH-1:0][TAG_W-1:0]  fl_put,
   input  logic [WIDTH-1:0][TAG_W-1:0]  fl_gotten,
   input  logic [TAG_W:0]               fl_len,
   output logic [1:0]                   ctrl_state,
   output logic                         free_overflow
`ifdef ALLOC_STALL_STATS_EN
   ,
   output logic [15:0]                  stall_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NUM_PREGS);

   function automatic logic [TAG_W:0] popcnt(input logic [WIDTH-1:0] v);
      popcnt = '0;
      for (int i = 0; i < WIDTH; i++)
         popcnt = popcnt + (TAG_W+1)'(v[i]);
   endfunction

   state_t                        state;
   state_t                        state_next;
   logic [WIDTH-1:0]              free_q_en;
   logic [WIDTH-1:0][TAG_W-1:0]   free_q_tag;
   logic                          transfer;
   logic                          put_overflow;
   logic [TAG_W+1:0]              occ_after_put;
   logic [TAG_W+1:0]              occ_limit;

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_INIT;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_INIT:  state_next = ST_FILL;
         ST_FILL:  if (fl_len == FULL) state_next = ST_RUN;
         ST_RUN:   if (flush) state_next = ST_FLUSH;
         ST_FLUSH: state_next = ST_RUN;
         default:  state_next = ST_INIT;
      endcase
   end

   assign ctrl_state = state;
   assign fl_rst     = (state == ST_INIT);

   // A group is granted only as a whole; a zero-slot request is always satisfiable in RUN.
   assign alloc_ready = (state == ST_RUN) && !flush && (fl_len >= popcnt(alloc_en));
   assign transfer    = alloc_valid && alloc_ready;
   assign fl_get_en   = transfer ? alloc_en : '0;

   always_comb begin
      alloc_tag = '0;
      for (int i = 0; i < WIDTH; i++)
         if (fl_get_en[i]) alloc_tag[i] = fl_gotten[i];
   end

   // Frees are staged one cycle so they can never be granted back in the cycle they arrive.
   always_ff @(posedge clk) begin
      if (!rst || state == ST_INIT) begin
         free_q_en  <= '0;
         free_q_tag <= '0;
      end else begin
         free_q_en  <= free_en;
         free_q_tag <= free_tag;
      end
   end

   // One extra bit keeps fl_len + pushes from wrapping before the compare.
   assign occ_after_put = {1'b0, fl_len} + {1'b0, popcnt(free_q_en)};
   assign occ_limit     = {1'b0, FULL} + {1'b0, popcnt(fl_get_en)};
   assign put_overflow  = occ_after_put > occ_limit;

   always_comb begin
      fl_put_en = '0;
      fl_put    = '0;
      if (!put_overflow) begin
         fl_put_en = free_q_en;
         for (int i = 0; i < WIDTH; i++)
            if (free_q_en[i]) fl_put[i] = free_q_tag[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)              free_overflow <= 1'b0;
      else if (put_overflow) free_overflow <= 1'b1;
   end

`ifdef ALLOC_STALL_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst)
         stall_cycles <= '0;
      else if (state == ST_RUN && alloc_valid && !alloc_ready && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_phys_tag_alloc_ctrl.sv
// Directed bench for phys_tag_alloc_ctrl with a behavioural free-list FIFO model
// whose occupancy can be overridden to reach boundary cases.
module tb_phys_tag_alloc_ctrl;

   logic                clk;
   logic                rst;
   logic                alloc_valid;
   logic [2:0]          alloc_en;
   logic                alloc_ready;
   logic [2:0][5:0]     alloc_tag;
   logic                flush;
   logic [2:0]          free_en;
   logic [2:0][5:0]     free_tag;
   logic                fl_rst;
   logic [2:0]          fl_get_en;
   logic [2:0]          fl_put_en;
   logic [2:0][5:0]     fl_put;
   logic [2:0][5:0]     fl_gotten;
   logic [6:0]          fl_len;
   logic [1:0]          ctrl_state;
   logic                free_overflow;
`ifdef ALLOC_STALL_STATS_EN
   logic [15:0]         stall_cycles;
`endif

   phys_tag_alloc_ctrl #(.NUM_PREGS(64), .TAG_W(6), .WIDTH(3)) dut (
      .clk(clk),
      .rst(rst),
      .alloc_valid(alloc_valid),
      .alloc_en(alloc_en),
      .alloc_ready(alloc_ready),
      .alloc_tag(alloc_tag),
      .flush(flush),
      .free_en(free_en),
      .free_tag(free_tag),
      .fl_rst(fl_rst),
      .fl_get_en(fl_get_en),
      .fl_put_en(fl_put_en),
      .fl_put(fl_put),
      .fl_gotten(fl_gotten),
      .fl_len(fl_len),
      .ctrl_state(ctrl_state),
      .free_overflow(free_overflow)
`ifdef ALLOC_STALL_STATS_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-list model: ring buffer, refilled with tags 0..63 whenever fl_rst is seen.
   logic [5:0]  mem [64];
   int          head;
   int          cnt;
   int          gk;
   int          pk;
   logic [2:0][5:0] push_addr;
   logic        ovr_en;
   logic [6:0]  ovr_len;

   assign fl_len = ovr_en ? ovr_len : 7'(cnt);

   always_comb begin
      fl_gotten = '0;
      gk = 0;
      for (int i = 0; i < 3; i++) begin
         fl_gotten[i] = mem[(head + gk) % 64];
         if (fl_get_en[i]) gk = gk + 1;
      end
   end

   always_comb begin
      push_addr = '0;
      pk = 0;
      for (int i = 0; i < 3; i++) begin
         push_addr[i] = 6'((head + cnt + pk) % 64);
         if (fl_put_en[i]) pk = pk + 1;
      end
   end

   always @(posedge clk) begin
      if (fl_rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 6'(i);
         head <= 0;
         cnt  <= 64;
      end else begin
         for (int i = 0; i < 3; i++)
            if (fl_put_en[i]) mem[push_addr[i]] <= fl_put[i];
         head <= (head + $countones(fl_get_en)) % 64;
         cnt  <= cnt - $countones(fl_get_en) + $countones(fl_put_en);
      end
   end

   typedef struct packed {
      logic            valid;
      logic [2:0]      en;
      logic [6:0]      len;
      logic            exp_ready;
      logic [2:0]      exp_get;
      logic [2:0][5:0] exp_tag;
   } vec_t;

   vec_t vecs [8];
   int   total;
   int   bad;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      alloc_valid = v.valid;
      alloc_en    = v.en;
      ovr_en      = 1'b1;
      ovr_len     = v.len;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      // Model head is 6 when the table starts; each transfer advances it.
      vecs[0] = '{1'b1, 3'b111, 7'd2, 1'b0, 3'b000, {6'd0,  6'd0,  6'd0}};
      vecs[1] = '{1'b1, 3'b101, 7'd2, 1'b1, 3'b101, {6'd7,  6'd0,  6'd6}};
      vecs[2] = '{1'b0, 3'b111, 7'd3, 1'b1, 3'b000, {6'd0,  6'd0,  6'd0}};
      vecs[3] = '{1'b1, 3'b000, 7'd0, 1'b1, 3'b000, {6'd0,  6'd0,  6'd0}};
      vecs[4] = '{1'b1, 3'b111, 7'd3, 1'b1, 3'b111, {6'd10, 6'd9,  6'd8}};
      vecs[5] = '{1'b1, 3'b010, 7'd0, 1'b0, 3'b000, {6'd0,  6'd0,  6'd0}};
      vecs[6] = '{1'b1, 3'b110, 7'd2, 1'b1, 3'b110, {6'd12, 6'd11, 6'd0}};
      vecs[7] = '{1'b1, 3'b011, 7'd1, 1'b0, 3'b000, {6'd0,  6'd0,  6'd0}};

      rst = 1'b0; alloc_valid = 1'b0; alloc_en = '0; flush = 1'b0;
      free_en = '0; free_tag = '0; ovr_en = 1'b0; ovr_len = '0;
      tick();
      tick();

      rst = 1'b1; alloc_valid = 1'b1; alloc_en = 3'b001;
      #1;
      checkOutput("init_state", 32'(ctrl_state), 32'd0);
      checkOutput("init_fl_rst", 32'(fl_rst), 32'd1);
      checkOutput("init_ready", 32'(alloc_ready), 32'd0);
      checkOutput("init_get_en", 32'(fl_get_en), 32'd0);
      checkOutput("init_put_en", 32'(fl_put_en), 32'd0);
      checkOutput("init_tag", 32'(alloc_tag), 32'd0);
      checkOutput("init_overflow", 32'(free_overflow), 32'd0);
      tick();
      checkOutput("fill_state", 32'(ctrl_state), 32'd1);
      checkOutput("fill_fl_rst", 32'(fl_rst), 32'd0);
      checkOutput("fill_ready", 32'(alloc_ready), 32'd0);
      alloc_valid = 1'b0;
      tick();
      checkOutput("run_state", 32'(ctrl_state), 32'd2);

      alloc_valid = 1'b1; alloc_en = 3'b111;
      #1;
      checkOutput("grp0_ready", 32'(alloc_ready), 32'd1);
      checkOutput("grp0_get", 32'(fl_get_en), 32'b111);
      checkOutput("grp0_tags", 32'(alloc_tag), 32'({6'd2, 6'd1, 6'd0}));
      tick();
      checkOutput("grp1_tags", 32'(alloc_tag), 32'({6'd5, 6'd4, 6'd3}));
      tick();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].exp_ready));
         checkOutput($sformatf("vec%0d_get", i), 32'(fl_get_en), 32'(vecs[i].exp_get));
         checkOutput($sformatf("vec%0d_tag", i), 32'(alloc_tag), 32'(vecs[i].exp_tag));
         tick();
      end
      ovr_en = 1'b0; alloc_valid = 1'b0; alloc_en = '0;
      #1;

      // Free two tags while granting one the next cycle; the pushed tags must not be granted.
      free_en = 3'b011; free_tag = {6'd0, 6'd9, 6'd7};
      #1;
      checkOutput("free_t0_put", 32'(fl_put_en), 32'd0);
      tick();
      free_en = '0; alloc_valid = 1'b1; alloc_en = 3'b001;
      #1;
      checkOutput("free_t1_put", 32'(fl_put_en), 32'b011);
      checkOutput("free_t1_data", 32'(fl_put[1:0]), 32'({6'd9, 6'd7}));
      checkOutput("free_t1_get", 32'(fl_get_en), 32'b001);
      checkOutput("free_t1_tag", 32'(alloc_tag[0]), 32'd13);
      checkOutput("free_t1_len", 32'(fl_len), 32'd51);
      tick();
      alloc_valid = 1'b0;
      #1;
      checkOutput("free_t2_len", 32'(fl_len), 32'd52);
      checkOutput("free_t2_put", 32'(fl_put_en), 32'd0);

      alloc_valid = 1'b1; alloc_en = 3'b001; flush = 1'b1;
      #1;
      checkOutput("flush_t0_ready", 32'(alloc_ready), 32'd0);
      checkOutput("flush_t0_get", 32'(fl_get_en), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      checkOutput("flush_t1_state", 32'(ctrl_state), 32'd3);
      checkOutput("flush_t1_ready", 32'(alloc_ready), 32'd0);
      tick();
      checkOutput("flush_t2_state", 32'(ctrl_state), 32'd2);
      checkOutput("flush_t2_ready", 32'(alloc_ready), 32'd1);
      checkOutput("flush_t2_tag", 32'(alloc_tag[0]), 32'd14);
      alloc_valid = 1'b0; alloc_en = '0;
      flush = 1'b1;
      tick();
      checkOutput("hold_flush_a", 32'(ctrl_state), 32'd3);
      tick();
      checkOutput("hold_flush_b", 32'(ctrl_state), 32'd2);
      checkOutput("hold_flush_rdy", 32'(alloc_ready), 32'd0);
      tick();
      checkOutput("hold_flush_c", 32'(ctrl_state), 32'd3);
      flush = 1'b0;
      tick();
      checkOutput("hold_flush_d", 32'(ctrl_state), 32'd2);

      // Occupancy boundaries: exactly full is legal, one past full is not.
      ovr_en = 1'b1; ovr_len = 7'd63;
      free_en = 3'b001; free_tag = {6'd0, 6'd0, 6'd20};
      tick();
      free_en = '0;
      #1;
      checkOutput("fill63_put", 32'(fl_put_en), 32'b001);
      tick();
      checkOutput("fill63_ovf", 32'(free_overflow), 32'd0);

      ovr_len = 7'd64;
      free_en = 3'b001; free_tag = {6'd0, 6'd0, 6'd21};
      tick();
      free_en = '0; alloc_valid = 1'b1; alloc_en = 3'b001;
      #1;
      checkOutput("full_swap_ready", 32'(alloc_ready), 32'd1);
      checkOutput("full_swap_put", 32'(fl_put_en), 32'b001);
      tick();
      alloc_valid = 1'b0; alloc_en = '0;
      #1;
      checkOutput("full_swap_ovf", 32'(free_overflow), 32'd0);

      free_en = 3'b001; free_tag = {6'd0, 6'd0, 6'd22};
      tick();
      free_en = '0;
      #1;
      checkOutput("ovf_put", 32'(fl_put_en), 32'd0);
      tick();
      checkOutput("ovf_flag", 32'(free_overflow), 32'd1);
      tick();
      tick();
      checkOutput("ovf_sticky", 32'(free_overflow), 32'd1);

      // Reset mid-run with frees in flight, then frees during INIT must be dropped.
      rst = 1'b0; free_en = 3'b111; free_tag = {6'd30, 6'd31, 6'd32};
      tick();
      ovr_en = 1'b0;
      #1;
      checkOutput("rst_state", 32'(ctrl_state), 32'd0);
      checkOutput("rst_ovf", 32'(free_overflow), 32'd0);
      checkOutput("rst_put", 32'(fl_put_en), 32'd0);
      checkOutput("rst_fl_rst", 32'(fl_rst), 32'd1);
      rst = 1'b1; free_en = 3'b011;
      tick();
      free_en = '0;
      #1;
      checkOutput("rerun_fill", 32'(ctrl_state), 32'd1);
      checkOutput("init_free_drop", 32'(fl_put_en), 32'd0);
      tick();
      checkOutput("rerun_run", 32'(ctrl_state), 32'd2);
      checkOutput("rerun_put", 32'(fl_put_en), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
